test_port_responder: RTL and testbench

TEST_PORT_RESPONDER -- requirements
Module: test_port_responder

---
 rtl/test_port_responder.sv | 101 ++++++++++
 tb/tb_test_port_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_port_responder.sv
// rtl/test_port_responder.sv - host test-port responder arbitrating memory and register-file access
// One host access at a time; each request is latched, executed for one cycle and acknowledged with done.
module test_port_responder (
   input  logic        clk,
   input  logic        reset,
   input  logic        test,
   input  logic        memoryoperation,
   input  logic        registeroperation,
   input  logic        memorywrite,
   input  logic        registerwrite,
   input  logic [15:0] memaddress,
   input  logic [15:0] memwritedata,
   input  logic [3:0]  registeraddress,
   input  logic [15:0] regwritedata,
   output logic [15:0] MD,
   output logic [15:0] RD,
   output logic        done,
   output logic        busy,
   output logic        core_en,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   output logic [3:0]  rf_addr,
   output logic [15:0] rf_wdata,
   output logic        rf_we,
   input  logic [15:0] rf_rdata
);

   typedef enum logic [2:0] {IDLE, MACC, RACC, DONE, HOLD} state_t;

   state_t      state;
   logic [15:0] lat_addr;
   logic [15:0] lat_wdata;
   logic        lat_we;
   logic        lat_mem;

   assign busy      = (state != IDLE);
   // The core is stopped combinationally the moment a host request shows up.
   assign core_en   = (state == IDLE) && test && !memoryoperation && !registeroperation;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign rf_addr   = lat_addr[3:0];
   assign rf_wdata  = lat_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         lat_addr  <= 16'h0000;
         lat_wdata <= 16'h0000;
         lat_we    <= 1'b0;
         lat_mem   <= 1'b0;
         MD        <= 16'h0000;
         RD        <= 16'h0000;
         done      <= 1'b0;
         mem_we    <= 1'b0;
         rf_we     <= 1'b0;
      end else begin
         done   <= 1'b0;
         mem_we <= 1'b0;
         rf_we  <= 1'b0;
         case (state)
            IDLE: begin
               if (memoryoperation) begin
                  lat_addr  <= memaddress;
                  lat_wdata <= memwritedata;
                  lat_we    <= memorywrite;
                  lat_mem   <= 1'b1;
                  mem_we    <= memorywrite;
                  state     <= MACC;
               end else if (registeroperation) begin
                  lat_addr  <= {12'h000, registeraddress};
                  lat_wdata <= regwritedata;
                  lat_we    <= registerwrite;
                  lat_mem   <= 1'b0;
                  rf_we     <= registerwrite;
                  state     <= RACC;
               end
            end
            MACC: begin
               MD    <= lat_we ? lat_wdata : mem_rdata;
               done  <= 1'b1;
               state <= DONE;
            end
            RACC: begin
               RD    <= lat_we ? lat_wdata : rf_rdata;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: state <= HOLD;
            // Only the level of the request just serviced releases HOLD.
            HOLD: begin
               if (lat_mem ? !memoryoperation : !registeroperation)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_test_port_responder.sv
// tb/tb_test_port_responder.sv - self-checking bench for test_port_responder
// Transaction-level reference model plus directed literal checks and randomized traffic.
module tb_test_port_responder;

   logic        clk;
   logic        reset;
   logic        test;
   logic        memoryoperation;
   logic        registeroperation;
   logic        memorywrite;
   logic        registerwrite;
   logic [15:0] memaddress;
   logic [15:0] memwritedata;
   logic [3:0]  registeraddress;
   logic [15:0] regwritedata;
   logic [15:0] MD;
   logic [15:0] RD;
   logic        done;
   logic        busy;
   logic        core_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic [3:0]  rf_addr;
   logic [15:0] rf_wdata;
   logic        rf_we;
   logic [15:0] rf_rdata;

   test_port_responder dut (
      .clk(clk), .reset(reset), .test(test),
      .memoryoperation(memoryoperation), .registeroperation(registeroperation),
      .memorywrite(memorywrite), .registerwrite(registerwrite),
      .memaddress(memaddress), .memwritedata(memwritedata),
      .registeraddress(registeraddress), .regwritedata(regwritedata),
      .MD(MD), .RD(RD), .done(done), .busy(busy), .core_en(core_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input logic [15:0] a);
      logic [15:0] p;
      p = a * 16'h9E37;
      return p ^ 16'hC3A5;
   endfunction

   // Bench-side storage driven only by the DUT's strobes.
   logic [15:0] mem_arr [0:65535];
   bit          mem_wr  [0:65535];
   logic [15:0] rf_arr  [0:15];
   bit          rf_wr   [0:15];

   assign mem_rdata = mem_wr[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr);
   assign rf_rdata  = rf_wr[rf_addr] ? rf_arr[rf_addr] : init_val({12'h000, rf_addr});

   always @(posedge clk) begin
      if (mem_we) begin
         mem_arr[mem_addr] <= mem_wdata;
         mem_wr[mem_addr]  <= 1'b1;
      end
      if (rf_we) begin
         rf_arr[rf_addr] <= rf_wdata;
         rf_wr[rf_addr]  <= 1'b1;
      end
   end

   // Reference model: one outstanding transaction, tracked by its age in cycles.
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] ref_rf  [logic [3:0]];
   bit          m_busy;
   bit          m_mem;
   bit          m_we;
   int          m_age;
   logic [15:0] m_addr;
   logic [15:0] m_data;
   logic [15:0] exp_md;
   logic [15:0] exp_rd;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int rfwe_cnt = 0;
   logic [15:0] expv;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_age  = 0;
      exp_md = 16'h0000;
      exp_rd = 16'h0000;
   endtask

   task automatic model_edge();
      if (reset) begin
         model_reset();
      end else if (!m_busy) begin
         if (memoryoperation) begin
            m_busy = 1'b1; m_mem = 1'b1; m_age = 0;
            m_addr = memaddress; m_data = memwritedata; m_we = memorywrite;
         end else if (registeroperation) begin
            m_busy = 1'b1; m_mem = 1'b0; m_age = 0;
            m_addr = {12'h000, registeraddress}; m_data = regwritedata; m_we = registerwrite;
         end
      end else begin
         m_age++;
         if (m_age == 1) begin
            if (m_mem) begin
               if (m_we) ref_mem[m_addr] = m_data;
               exp_md = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_val(m_addr);
            end else begin
               if (m_we) ref_rf[m_addr[3:0]] = m_data;
               exp_rd = ref_rf.exists(m_addr[3:0]) ? ref_rf[m_addr[3:0]] : init_val(m_addr);
            end
         end else if (m_age >= 3 && !(m_mem ? memoryoperation : registeroperation)) begin
            m_busy = 1'b0;
         end
      end
   endtask

   task automatic compare();
      bit e_access;
      e_access = m_busy && (m_age == 0);
      chk("busy", busy, m_busy);
      chk("done", done, m_busy && m_age == 1);
      chk("mem_we", mem_we, e_access && m_mem && m_we);
      chk("rf_we", rf_we, e_access && !m_mem && m_we);
      chk("we_exclusive", mem_we && rf_we, 1'b0);
      chk("MD", MD, exp_md);
      chk("RD", RD, exp_rd);
      chk("core_en", core_en, !m_busy && test && !memoryoperation && !registeroperation);
      if (e_access && m_mem) begin
         chk("mem_addr", mem_addr, m_addr);
         if (m_we) chk("mem_wdata", mem_wdata, m_data);
      end
      if (e_access && !m_mem) begin
         chk("rf_addr", rf_addr, m_addr[3:0]);
         if (m_we) chk("rf_wdata", rf_wdata, m_data);
      end
   endtask

   // Inputs are applied 1 time unit after a rising edge; outputs are checked 1 unit later.
   task automatic tick();
      if (reset) model_reset();
      #1 compare();
      @(posedge clk);
      model_edge();
      #1;
      done_cnt += int'(done);
      rfwe_cnt += int'(rf_we);
   endtask

   initial begin
      reset = 1'b1; test = 1'b0;
      memoryoperation = 1'b0; registeroperation = 1'b0;
      memorywrite = 1'b0; registerwrite = 1'b0;
      memaddress = 16'h0000; memwritedata = 16'h0000;
      registeraddress = 4'h0; regwritedata = 16'h0000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_MD", MD, 16'h0000);
      chk("rst_RD", RD, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      reset = 1'b0; test = 1'b1;
      tick();

      // Memory write to 0003
      memoryoperation = 1'b1; memorywrite = 1'b1; memaddress = 16'h0003; memwritedata = 16'hEE02;
      tick();
      chk("mw_mem_we", mem_we, 1'b1);
      chk("mw_mem_addr", mem_addr, 16'h0003);
      memaddress = 16'hFFFF; memwritedata = 16'h0000; memorywrite = 1'b0;
      tick();
      chk("mw_MD", MD, 16'hEE02);
      chk("mw_done", done, 1'b1);
      chk("mw_we_off", mem_we, 1'b0);
      tick();
      memoryoperation = 1'b0;
      tick();
      chk("mw_busy_low", busy, 1'b0);
      tick();

      // Register 0 write then read
      rfwe_cnt = 0;
      registeroperation = 1'b1; registerwrite = 1'b1; registeraddress = 4'h0; regwritedata = 16'h000B;
      tick();
      chk("rw_rf_we", rf_we, 1'b1);
      tick();
      chk("rw_RD", RD, 16'h000B);
      registeroperation = 1'b0;
      repeat (2) tick();
      registeroperation = 1'b1; registerwrite = 1'b0; regwritedata = 16'h7777;
      tick();
      tick();
      chk("rr_RD", RD, 16'h000B);
      chk("rr_done", done, 1'b1);
      registeroperation = 1'b0;
      repeat (2) tick();
      chk("rw_we_count", rfwe_cnt[15:0], 16'd1);

      // Simultaneous requests: memory first, register after memory drops
      done_cnt = 0;
      memoryoperation = 1'b1; registeroperation = 1'b1; memorywrite = 1'b0;
      memaddress = 16'h0005; registeraddress = 4'h2;
      repeat (5) tick();
      chk("tie_one_done", done_cnt[15:0], 16'd1);
      chk("tie_RD_held", RD, 16'h000B);
      memoryoperation = 1'b0;
      repeat (3) tick();
      expv = init_val(16'h0002);
      chk("tie_RD", RD, expv);
      chk("tie_two_done", done_cnt[15:0], 16'd2);
      registeroperation = 1'b0;
      repeat (3) tick();

      // core_en handshake
      #1 chk("ce_idle", core_en, 1'b1);
      memoryoperation = 1'b1; memaddress = 16'h0003;
      #1 chk("ce_drop", core_en, 1'b0);
      repeat (3) tick();
      memoryoperation = 1'b0;
      #1 chk("ce_hold", core_en, 1'b0);
      tick();
      chk("ce_back", core_en, 1'b1);
      tick();

      // Reset during a write to 0004, request still held afterwards
      done_cnt = 0;
      memoryoperation = 1'b1; memorywrite = 1'b1; memaddress = 16'h0004; memwritedata = 16'h1234;
      tick();
      chk("ra_mem_we", mem_we, 1'b1);
      reset = 1'b1;
      #1;
      chk("ra_we_drop", mem_we, 1'b0);
      chk("ra_MD", MD, 16'h0000);
      chk("ra_idle", busy, 1'b0);
      tick();
      memorywrite = 1'b0;
      reset = 1'b0;
      tick();
      chk("ra_no_done", done_cnt[15:0], 16'd0);
      chk("ra_restart", busy, 1'b1);
      tick();
      expv = init_val(16'h0004);
      chk("ra_MD_read", MD, expv);
      memoryoperation = 1'b0;
      repeat (3) tick();

      // Long-held register request serviced once
      done_cnt = 0; rfwe_cnt = 0;
      registeroperation = 1'b1; registerwrite = 1'b1; registeraddress = 4'h7; regwritedata = 16'h1357;
      repeat (10) tick();
      chk("hold_rf_we_once", rfwe_cnt[15:0], 16'd1);
      chk("hold_done_once", done_cnt[15:0], 16'd1);
      registeroperation = 1'b0;
      repeat (3) tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 15) == 0) test = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) memoryoperation = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) registeroperation = 1'($urandom_range(0, 1));
         memorywrite = 1'($urandom_range(0, 1));
         registerwrite = 1'($urandom_range(0, 1));
         memaddress = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
         memwritedata = 16'($urandom);
         registeraddress = 4'($urandom_range(0, 15));
         regwritedata = 16'($urandom);
         tick();
      end
      reset = 1'b0; memoryoperation = 1'b0; registeroperation = 1'b0;
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
